// File: rtl/cleared_ram.sv
// cleared_ram: single-port synchronous RAM with per-byte write masks,
// a gated read path with a read_valid strobe, a selectable
// read-during-write mode, an optional output register, and a clear
// engine. The clear engine fills the whole array with CLEAR_VALUE
// after reset or on request, so stale contents never leak out after
// a reset.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset; starts a clear
//   clear       request a full-array clear (taken only when idle)
//   address     read/write address
//   read_en     read request for address
//   write_en    write request for address
//   write_mask  per-byte-lane write enable (top lane may be partial)
//   write_data  write data
//   read_data   read result; holds when no read completes
//   read_valid  strobe: read_data carries a completed read
//   busy        clear engine running; user accesses are ignored
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_CLEAR | writing CLEAR_VALUE to ram[ccnt], one entry per cycle
// ST_IDLE  | user reads/writes accepted; clear request starts CLEAR

module cleared_ram #(
    parameter int              SIZE        = 8,
    parameter int              DEPTH       = 16,
    parameter int              RD_MODE     = 0,
    parameter int              OUT_REG     = 0,
    parameter logic [SIZE-1:0] CLEAR_VALUE = '0,
    localparam int             AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int             MW          = (SIZE + 7) / 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic [AW-1:0]   address,
    input  logic            read_en,
    input  logic            write_en,
    input  logic [MW-1:0]   write_mask,
    input  logic [SIZE-1:0] write_data,
    output logic [SIZE-1:0] read_data,
    output logic            read_valid,
    output logic            busy
);

    // Array rows are padded to whole bytes so every lane can use a
    // uniform 8-bit slice; the pad bits of a partial top lane are
    // never read back.
    localparam int PW = MW * 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ccnt, ccnt_nxt;
    logic            clearing, idle;

    logic [PW-1:0]   ram [DEPTH];

    logic            in_range;
    logic            rd_acc;
    logic            wr_go;
    logic [AW-1:0]   wr_idx;
    logic [MW-1:0]   wr_lanes;
    logic [PW-1:0]   wr_word;

    logic [SIZE-1:0] ram_q;
    logic            byp_hit;
    logic [MW-1:0]   byp_mask;
    logic [SIZE-1:0] byp_data;
    logic            rd_v1;
    logic            rd_zero;
    logic [SIZE-1:0] s1_word;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
            ccnt  <= '0;
        end else begin
            state <= state_nxt;
            ccnt  <= ccnt_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        ccnt_nxt  = ccnt;
        case (state)
            ST_CLEAR: begin
                ccnt_nxt = ccnt + 1'b1;
                if (ccnt == AW'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                    ccnt_nxt  = '0;
                end
            end
            default: begin
                if (clear) begin
                    state_nxt = ST_CLEAR;
                    ccnt_nxt  = '0;
                end
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        clearing = (state == ST_CLEAR);
        idle     = (state == ST_IDLE);
        busy     = clearing;
    end

    // ---------------- access decode ----------------
    always_comb begin
        in_range = ({{(32 - AW){1'b0}}, address} < 32'(DEPTH));
        rd_acc   = idle && !rst && read_en;
        wr_go    = clearing || (idle && !rst && write_en && in_range);
        wr_idx   = clearing ? ccnt : address;
        wr_lanes = clearing ? {MW{1'b1}} : write_mask;
        wr_word  = '0;
        wr_word[SIZE-1:0] = clearing ? CLEAR_VALUE : write_data;
    end

    // ---------------- array (no reset, block-RAM style) ----------------
    // The read port is read-first; write-first behaviour is rebuilt
    // after the array from the registered bypass fields below.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int i = 0; i < MW; i++) begin
                if (wr_lanes[i]) begin
                    ram[wr_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
        if (rd_acc && in_range) begin
            ram_q <= ram[address][SIZE-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            byp_hit  <= write_en && in_range;
            byp_mask <= write_mask;
            byp_data <= write_data;
        end
    end

    // rd_zero forces the result to 0 after reset and for out-of-range
    // reads, so ram_q itself never needs a reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_v1   <= 1'b0;
            rd_zero <= 1'b1;
        end else begin
            rd_v1 <= rd_acc;
            if (rd_acc) begin
                rd_zero <= !in_range;
            end
        end
    end

    always_comb begin
        s1_word = ram_q;
        if ((RD_MODE != 0) && byp_hit) begin
            for (int b = 0; b < SIZE; b++) begin
                if (byp_mask[b / 8]) begin
                    s1_word[b] = byp_data[b];
                end
            end
        end
        if (rd_zero) begin
            s1_word = '0;
        end
    end

    // ---------------- optional output register ----------------
    generate
        if (OUT_REG != 0) begin : g_oreg
            logic            rd_v2;
            logic [SIZE-1:0] rd_d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_v2 <= 1'b0;
                    rd_d2 <= '0;
                end else begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) begin
                        rd_d2 <= s1_word;
                    end
                end
            end

            assign read_valid = rd_v2;
            assign read_data  = rd_d2;
        end else begin : g_noreg
            assign read_valid = rd_v1;
            assign read_data  = s1_word;
        end
    endgenerate

endmodule
